// File: rtl/cache_axi_refill.sv
// Cache miss-service engine: dirty-victim write-back, 64-byte line refill over AXI,
// and single-beat uncached loads/stores. All AXI outputs come straight from registers.
module cache_axi_refill #(
    parameter int LINE_WORDS = 16,
    parameter int CNT_WD     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    cached,
    input  logic                    sram_en,
    input  logic [3:0]              sram_we,
    input  logic [31:0]             sram_addr,
    input  logic [31:0]             sram_wdata,
    input  logic                    miss,
    input  logic                    write_back,
    input  logic [31:0]             axi_raddr,
    input  logic [31:0]             axi_waddr,
    input  logic [32*LINE_WORDS-1:0] victim_line,
    output logic                    refresh,
    output logic [32*LINE_WORDS-1:0] refill_line,
    output logic                    uc_done,
    output logic [31:0]             uc_rdata,
    output logic                    busy,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [31:0]             rdata,
    input  logic                    rlast,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam logic [7:0]        BURST_LEN = 8'(LINE_WORDS - 1);
    localparam logic [CNT_WD-1:0] LAST_CNT  = CNT_WD'(LINE_WORDS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WB_AW,
        S_WB_W,
        S_WB_B,
        S_RD_AR,
        S_RD_R,
        S_REFRESH,
        S_UC_AR,
        S_UC_R,
        S_UC_AW,
        S_UC_W,
        S_UC_B,
        S_UC_DONE
    } state_t;

    state_t            r_state;
    logic [CNT_WD-1:0] r_cnt;
    logic [31:0]       r_raddr;
    logic [31:0]       r_victim [LINE_WORDS];
    logic [31:0]       r_refill [LINE_WORDS];
    logic [31:0]       w_victim_word [LINE_WORDS];
    logic [CNT_WD-1:0] w_cnt_inc;

    logic        r_refresh;
    logic        r_uc_done;
    logic [31:0] r_uc_rdata;
    logic        r_arvalid;
    logic [31:0] r_araddr;
    logic [7:0]  r_arlen;
    logic        r_rready;
    logic        r_awvalid;
    logic [31:0] r_awaddr;
    logic [7:0]  r_awlen;
    logic        r_wvalid;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_wlast;
    logic        r_bready;

    assign w_cnt_inc = r_cnt + 1'b1;

    // Flat line buses <-> word arrays, word i at bits [32i+31:32i].
    generate
        for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_words
            assign w_victim_word[gi]         = victim_line[32*gi +: 32];
            assign refill_line[32*gi +: 32]  = r_refill[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_raddr    <= '0;
            r_refresh  <= 1'b0;
            r_uc_done  <= 1'b0;
            r_uc_rdata <= '0;
            r_arvalid  <= 1'b0;
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_rready   <= 1'b0;
            r_awvalid  <= 1'b0;
            r_awaddr   <= '0;
            r_awlen    <= '0;
            r_wvalid   <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wlast    <= 1'b0;
            r_bready   <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_victim[i] <= '0;
                r_refill[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A cached miss outranks a simultaneous uncached request.
                    if (!flush) begin
                        if (miss) begin
                            r_raddr <= axi_raddr;
                            if (write_back) begin
                                r_awaddr  <= axi_waddr;
                                r_awlen   <= BURST_LEN;
                                r_awvalid <= 1'b1;
                                for (int i = 0; i < LINE_WORDS; i++) begin
                                    r_victim[i] <= w_victim_word[i];
                                end
                                r_state <= S_WB_AW;
                            end else begin
                                r_araddr  <= axi_raddr;
                                r_arlen   <= BURST_LEN;
                                r_arvalid <= 1'b1;
                                r_state   <= S_RD_AR;
                            end
                        end else if (!cached && sram_en) begin
                            if (sram_we == 4'h0) begin
                                r_araddr  <= sram_addr;
                                r_arlen   <= 8'h00;
                                r_arvalid <= 1'b1;
                                r_state   <= S_UC_AR;
                            end else begin
                                r_awaddr  <= sram_addr;
                                r_awlen   <= 8'h00;
                                r_awvalid <= 1'b1;
                                r_wstrb   <= sram_we;
                                r_wdata   <= sram_wdata;
                                r_state   <= S_UC_AW;
                            end
                        end
                    end
                end

                S_WB_AW: begin
                    if (awready) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_wdata   <= r_victim[0];
                        r_wstrb   <= 4'hF;
                        r_wlast   <= (LINE_WORDS == 1);
                        r_cnt     <= '0;
                        r_state   <= S_WB_W;
                    end
                end

                S_WB_W: begin
                    if (wready) begin
                        if (r_wlast) begin
                            r_wvalid <= 1'b0;
                            r_wlast  <= 1'b0;
                            r_cnt    <= '0;
                            r_bready <= 1'b1;
                            r_state  <= S_WB_B;
                        end else begin
                            r_cnt   <= w_cnt_inc;
                            r_wdata <= r_victim[w_cnt_inc];
                            r_wlast <= (w_cnt_inc == LAST_CNT);
                        end
                    end
                end

                S_WB_B: begin
                    if (bvalid) begin
                        r_bready  <= 1'b0;
                        r_araddr  <= r_raddr;
                        r_arlen   <= BURST_LEN;
                        r_arvalid <= 1'b1;
                        r_state   <= S_RD_AR;
                    end
                end

                S_RD_AR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_RD_R;
                    end
                end

                S_RD_R: begin
                    // The slave's rlast ends the burst; the beat count is not cross-checked.
                    if (rvalid) begin
                        r_refill[r_cnt] <= rdata;
                        r_cnt           <= w_cnt_inc;
                        if (rlast) begin
                            r_rready  <= 1'b0;
                            r_cnt     <= '0;
                            r_refresh <= 1'b1;
                            r_state   <= S_REFRESH;
                        end
                    end
                end

                S_REFRESH: begin
                    r_refresh <= 1'b0;
                    r_state   <= S_IDLE;
                end

                S_UC_AR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_UC_R;
                    end
                end

                S_UC_R: begin
                    if (rvalid) begin
                        r_uc_rdata <= rdata;
                        r_rready   <= 1'b0;
                        r_uc_done  <= 1'b1;
                        r_state    <= S_UC_DONE;
                    end
                end

                S_UC_AW: begin
                    if (awready) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_wlast   <= 1'b1;
                        r_state   <= S_UC_W;
                    end
                end

                S_UC_W: begin
                    if (wready) begin
                        r_wvalid <= 1'b0;
                        r_wlast  <= 1'b0;
                        r_bready <= 1'b1;
                        r_state  <= S_UC_B;
                    end
                end

                S_UC_B: begin
                    if (bvalid) begin
                        r_bready  <= 1'b0;
                        r_uc_done <= 1'b1;
                        r_state   <= S_UC_DONE;
                    end
                end

                S_UC_DONE: begin
                    r_uc_done <= 1'b0;
                    r_state   <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign refresh  = r_refresh;
    assign uc_done  = r_uc_done;
    assign uc_rdata = r_uc_rdata;
    assign busy     = (r_state != S_IDLE);
    assign arvalid  = r_arvalid;
    assign araddr   = r_araddr;
    assign arlen    = r_arlen;
    assign arsize   = 3'b010;
    assign arburst  = 2'b01;
    assign rready   = r_rready;
    assign awvalid  = r_awvalid;
    assign awaddr   = r_awaddr;
    assign awlen    = r_awlen;
    assign awsize   = 3'b010;
    assign awburst  = 2'b01;
    assign wvalid   = r_wvalid;
    assign wdata    = r_wdata;
    assign wstrb    = r_wstrb;
    assign wlast    = r_wlast;
    assign bready   = r_bready;

endmodule
